// File: rtl/mac_pkg.sv
// Shared types and parameter defaults for the MAC transmit arbiter.
package mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_ABORT = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_t;

   localparam int unsigned MAX_LEN_DEFAULT        = 1518;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mac_tx_rr2.sv
// Two-way packet-level round-robin pick: on contention the source not served last wins.
module mac_tx_rr2
   import mac_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_served,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_served ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Two-source AXI-stream packet arbiter into the MAC TX path with length abort/drain.
// Optional source-stall timeout is built when MAC_TX_ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no grant; pick a requesting source for the next cycle
// ST_PASS  | granted source wired straight through to the MAC
// ST_ABORT | presenting the drop beat (tuser=1, tlast=1) until MAC accepts
// ST_DRAIN | swallowing the rest of the granted packet up to tlast/tuser
module mac_tx_arbiter
   import mac_pkg::*;
#(
   parameter int unsigned MAX_LEN        = MAX_LEN_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s0_tdata,
   input  logic       s0_tvalid,
   input  logic       s0_tlast,
   input  logic       s0_tuser,
   output logic       s0_tready,
   input  logic [7:0] s1_tdata,
   input  logic       s1_tvalid,
   input  logic       s1_tlast,
   input  logic       s1_tuser,
   output logic       s1_tready,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   output logic       m_tlast,
   output logic       m_tuser,
   input  logic       m_tready,
   output logic [1:0] grant,
   output logic [7:0] abort_count
);

   if (MAX_LEN < 1 || MAX_LEN > 65535 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $error("mac_tx_arbiter: MAX_LEN/TIMEOUT_CYCLES out of range 1..65535");
   end

   // The drop beat occupies the last slot, so a packet never exceeds MAX_LEN beats on the wire.
   localparam logic [15:0] ABORT_AT = 16'(MAX_LEN - 1);

   arb_state_t  state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        last_q, last_d;
   logic [15:0] beat_q, beat_d;
   logic [7:0]  abort_q, abort_d;
   logic [1:0]  rr_gnt;
   logic [15:0] beat_inc;
   logic        g_ready;
   logic [7:0]  g_tdata;
   logic        g_tvalid, g_tlast, g_tuser;

   mac_tx_rr2 u_rr (
      .req         ({s1_tvalid, s0_tvalid}),
      .last_served (last_q),
      .gnt         (rr_gnt)
   );

   assign g_tdata  = grant_q[1] ? s1_tdata  : s0_tdata;
   assign g_tvalid = grant_q[1] ? s1_tvalid : s0_tvalid;
   assign g_tlast  = grant_q[1] ? s1_tlast  : s0_tlast;
   assign g_tuser  = grant_q[1] ? s1_tuser  : s0_tuser;
   assign beat_inc = beat_q + 16'd1;

`ifdef MAC_TX_ARB_TIMEOUT_EN
   localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES);
   logic [15:0] stall_q, stall_d;
   logic [15:0] stall_inc;

   assign stall_inc = stall_q + 16'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (state_q == ST_IDLE) begin
         stall_d = '0;
      end else if (state_q == ST_PASS) begin
         stall_d = g_tvalid ? 16'd0 : stall_inc;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= 1'b1;
         beat_q  <= '0;
         abort_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      beat_d   = beat_q;
      abort_d  = abort_q;
      m_tdata  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      m_tuser  = 1'b0;
      g_ready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rr_gnt != 2'b00) begin
               grant_d = rr_gnt;
               beat_d  = '0;
               state_d = ST_PASS;
            end
         end
         ST_PASS: begin
            m_tdata  = g_tdata;
            m_tvalid = g_tvalid;
            m_tlast  = g_tlast;
            m_tuser  = g_tuser;
            g_ready  = m_tready;
            if (g_tvalid && m_tready) begin
               beat_d = beat_inc;
               if (g_tlast || g_tuser) begin
                  last_d  = grant_q[1];
                  grant_d = '0;
                  state_d = ST_IDLE;
               end else if (beat_inc >= ABORT_AT) begin
                  state_d = ST_ABORT;
               end
            end
`ifdef MAC_TX_ARB_TIMEOUT_EN
            if (!g_tvalid && stall_inc >= STALL_LIMIT) begin
               state_d = ST_ABORT;
            end
`endif
         end
         ST_ABORT: begin
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            m_tuser  = 1'b1;
            if (m_tready) begin
               abort_d = sat_inc8(abort_q);
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            g_ready = 1'b1;
            if (g_tvalid && (g_tlast || g_tuser)) begin
               last_d  = grant_q[1];
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign s0_tready   = g_ready & grant_q[0];
   assign s1_tready   = g_ready & grant_q[1];
   assign grant       = grant_q;
   assign abort_count = abort_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Self-checking bench for mac_tx_arbiter: directed scenarios plus randomized packets
// scored against a per-source packet model (pass through, or truncate and drop-beat).
module tb_mac_tx_arbiter;

   localparam int MAXL = 8;
   localparam int TMO  = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s0_tdata, s1_tdata, m_tdata;
   logic       s0_tvalid, s0_tlast, s0_tuser, s0_tready;
   logic       s1_tvalid, s1_tlast, s1_tuser, s1_tready;
   logic       m_tvalid, m_tlast, m_tuser, m_tready;
   logic [1:0] grant;
   logic [7:0] abort_count;

   int    total = 0;
   int    bad = 0;
   beat_t src_q[2][$];
   beat_t exp_q[2][$];
   int    gap[2];
   int    gap_max = 0;
   int    rdy_mode = 0;
   int    cyc = 0;
   int    model_aborts = 0;
   logic [1:0] prev_grant = 2'b00;
   int    log_src[$];
   int    log_cyc[$];

   mac_tx_arbiter #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_tready(s0_tready),
      .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_tready(s1_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tready(m_tready),
      .grant(grant), .abort_count(abort_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Packet model: up to MAXL-1 beats pass unchanged; longer packets keep the first
   // MAXL-1 beats, then a single zero-data drop beat, and the rest is swallowed.
   task automatic push_pkt(input int s, input int len, input bit user_end);
      beat_t b;
      for (int k = 1; k <= len; k++) begin
         b.d = {s[0], 7'($urandom)};
         b.l = (k == len);
         b.u = user_end && (k == len);
         src_q[s].push_back(b);
         if (len <= MAXL - 1) exp_q[s].push_back(b);
         else if (k <= MAXL - 1) exp_q[s].push_back(b);
      end
      if (len > MAXL - 1) begin
         b = {8'h00, 1'b1, 1'b1};
         exp_q[s].push_back(b);
         model_aborts++;
      end
   endtask

   task automatic drive_sources();
      beat_t b0, b1;
      logic  v0, v1;
      v0 = !rst && gap[0] == 0 && src_q[0].size() > 0;
      v1 = !rst && gap[1] == 0 && src_q[1].size() > 0;
      b0 = v0 ? src_q[0][0] : '0;
      b1 = v1 ? src_q[1][0] : '0;
      s0_tvalid = v0; s0_tdata = b0.d; s0_tlast = b0.l; s0_tuser = b0.u;
      s1_tvalid = v1; s1_tdata = b1.d; s1_tlast = b1.l; s1_tuser = b1.u;
   endtask

   task automatic cycle();
      bit    f0, f1, mf;
      beat_t got, want, b;
      int    s;
      @(negedge clk);
      f0 = s0_tvalid && s0_tready;
      f1 = s1_tvalid && s1_tready;
      mf = m_tvalid && m_tready;
      if (prev_grant != 2'b00 && grant != 2'b00) check("grant_hold", 32'(grant), 32'(prev_grant));
      prev_grant = grant;
      if (mf) begin
         check("grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 1);
         s = int'(grant[1]);
         got = {m_tdata, m_tlast, m_tuser};
         if (exp_q[s].size() == 0) begin
            check($sformatf("beat_expected_s%0d", s), 32'(exp_q[s].size()), 1);
         end else begin
            want = exp_q[s].pop_front();
            check($sformatf("beat_s%0d", s), 32'(got), 32'(want));
         end
         log_src.push_back(s);
         log_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (f0) begin
         b = src_q[0].pop_front();
         if (b.l || b.u) gap[0] = $urandom_range(gap_max);
      end else if (gap[0] > 0) gap[0]--;
      if (f1) begin
         b = src_q[1].pop_front();
         if (b.l || b.u) gap[1] = $urandom_range(gap_max);
      end else if (gap[1] > 0) gap[1]--;
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = ($urandom_range(3) != 0);
      endcase
      cyc++;
      drive_sources();
   endtask

   task automatic run_until_empty(input int budget);
      int n = 0;
      while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 && n < budget) begin
         cycle();
         n++;
      end
      cycle();
      cycle();
      check("drained_src", 32'(src_q[0].size() + src_q[1].size()), 0);
      check("drained_exp", 32'(exp_q[0].size() + exp_q[1].size()), 0);
   endtask

   initial begin
      beat_t b;
      int    n;
      gap[0] = 0;
      gap[1] = 0;
      m_tready = 1'b1;
      drive_sources();

      // reset state
      @(negedge clk);
      check("rst_m_tvalid", 32'(m_tvalid), 0);
      check("rst_m_tlast", 32'(m_tlast), 0);
      check("rst_m_tuser", 32'(m_tuser), 0);
      check("rst_m_tdata", 32'(m_tdata), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_s0_tready", 32'(s0_tready), 0);
      check("rst_s1_tready", 32'(s1_tready), 0);
      check("rst_abort_count", 32'(abort_count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_sources();

      // both sources contend after reset: source 0 first, then source 1
      push_pkt(0, 4, 0);
      push_pkt(1, 4, 0);
      drive_sources();
      log_src.delete(); log_cyc.delete();
      run_until_empty(100);
      check("rr_beats", 32'(log_src.size()), 8);
      for (int i = 0; i < 8 && i < log_src.size(); i++)
         check($sformatf("rr_order_%0d", i), 32'(log_src[i]), (i < 4) ? 0 : 1);

      // MAC backpressure every other cycle
      rdy_mode = 1;
      push_pkt(1, 3, 0);
      drive_sources();
      log_src.delete(); log_cyc.delete();
      run_until_empty(100);
      check("bp_beats", 32'(log_src.size()), 3);
      check("bp_abort_count", 32'(abort_count), 0);

      // oversize packet: 7 beats, drop beat, remainder drained
      rdy_mode = 0;
      push_pkt(0, 12, 0);
      drive_sources();
      log_src.delete(); log_cyc.delete();
      run_until_empty(200);
      check("long_out_beats", 32'(log_src.size()), 8);
      check("long_abort_count", 32'(abort_count), 1);

      // length boundaries and source tuser end
      push_pkt(1, 7, 0);
      push_pkt(0, 8, 0);
      push_pkt(1, 5, 1);
      drive_sources();
      run_until_empty(200);
      check("bound_abort_count", 32'(abort_count), 32'(model_aborts));

      // source 0 stalls mid-packet after two beats
      log_src.delete(); log_cyc.delete();
      for (int k = 0; k < 2; k++) begin
         b = {8'(8'h10 + k), 1'b0, 1'b0};
         src_q[0].push_back(b);
         exp_q[0].push_back(b);
      end
`ifdef MAC_TX_ARB_TIMEOUT_EN
      b = {8'h00, 1'b1, 1'b1};
      exp_q[0].push_back(b);
      model_aborts++;
`endif
      drive_sources();
      run_until_empty(100);
`ifdef MAC_TX_ARB_TIMEOUT_EN
      check("stall_out_beats", 32'(log_cyc.size()), 3);
      if (log_cyc.size() >= 3) check("stall_abort_delay", 32'(log_cyc[2] - log_cyc[1]), TMO + 1);
`endif
      repeat (40) cycle();
      check("stall_grant", 32'(grant), 32'h1);
      check("stall_m_tvalid", 32'(m_tvalid), 0);
      check("stall_abort_count", 32'(abort_count), 32'(model_aborts));
      b = {8'h12, 1'b1, 1'b0};
      src_q[0].push_back(b);
`ifndef MAC_TX_ARB_TIMEOUT_EN
      exp_q[0].push_back(b);
`endif
      drive_sources();
      run_until_empty(100);
      check("stall_end_grant", 32'(grant), 0);

      // randomized traffic with gaps and random MAC backpressure
      rdy_mode = 2;
      gap_max = 3;
      for (int p = 0; p < 30; p++) begin
         push_pkt(0, $urandom_range(12, 1), $urandom_range(5) == 0);
         push_pkt(1, $urandom_range(12, 1), $urandom_range(5) == 0);
      end
      drive_sources();
      run_until_empty(5000);
      check("rand_abort_count", 32'(abort_count), (model_aborts > 255) ? 255 : model_aborts);

      // reset in the middle of a source 1 packet
      rdy_mode = 0;
      gap_max = 0;
      gap[0] = 0;
      gap[1] = 0;
      push_pkt(0, 2, 0);
      drive_sources();
      run_until_empty(100);
      push_pkt(1, 6, 0);
      drive_sources();
      log_src.delete(); log_cyc.delete();
      n = 0;
      while (log_src.size() < 2 && n < 50) begin
         cycle();
         n++;
      end
      check("mid_beat3_valid", 32'(m_tvalid), 1);
      rst = 1'b1;
      src_q[0].delete(); src_q[1].delete();
      exp_q[0].delete(); exp_q[1].delete();
      model_aborts = 0;
      drive_sources();
      @(negedge clk);
      check("mid_rst_m_tvalid", 32'(m_tvalid), 0);
      check("mid_rst_grant", 32'(grant), 0);
      check("mid_rst_abort_count", 32'(abort_count), 0);
      check("mid_rst_s1_tready", 32'(s1_tready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      prev_grant = 2'b00;
      push_pkt(0, 2, 0);
      push_pkt(1, 2, 0);
      drive_sources();
      log_src.delete(); log_cyc.delete();
      run_until_empty(100);
      check("post_rst_beats", 32'(log_src.size()), 4);
      if (log_src.size() > 0) check("post_rst_first_src", 32'(log_src[0]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
